// File: rtl/seven_seg_scan_driver_if.sv
// Datapath-to-display bus for seven_seg_scan_driver.
// master: producer of digit values (datapath / testbench).
// slave : the scan driver itself.
interface seven_seg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic                load;
    logic [6:0]          seg_n;
    logic                dp_n;
    logic [DIGITS-1:0]   an_n;
    logic                frame_tick;

    modport master (
        output value, dp, blank, load,
        input  seg_n, dp_n, an_n, frame_tick
    );

    modport slave (
        input  value, dp, blank, load,
        output seg_n, dp_n, an_n, frame_tick
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scan driver.
// Digits are scanned round-robin, CLK_DIV cycles per slot, with the first
// GUARD cycles of each slot dark to avoid ghosting. Inputs are captured into
// a pending buffer and promoted to the display buffer only at frame end, so
// a frame never mixes old and new digits.
// Optional: define LEADING_ZERO_BLANK_EN to auto-blank leading zero digits.
module seven_seg_scan_driver #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000,
    parameter int GUARD   = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    seven_seg_scan_driver_if.slave bus
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef logic [DIGITS-1:0][3:0] nib_t;

    logic [CNT_W-1:0]  div_cnt;
    logic [IDX_W-1:0]  idx;
    nib_t              disp_val, pend_val;
    logic [DIGITS-1:0] disp_dp, disp_blank, pend_dp, pend_blank;
    logic              pend_valid;

    logic              slot_end, frame_end;
    logic [DIGITS-1:0] lz_blank;
    logic              in_guard, blanked;
    logic [DIGITS-1:0] an_d;
    logic [6:0]        seg_d;
    logic              dp_d;

    assign slot_end  = (div_cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Active-low glyphs {g,f,e,d,c,b,a}; b and d are lower case.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // Slot divider and digit index; scanning always restarts at digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // Double buffer: last load in a frame wins; a load in the frame-end
    // cycle bypasses pending so it is shown in the very next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
        end else begin
            if (bus.load) begin
                pend_val   <= nib_t'(bus.value);
                pend_dp    <= bus.dp;
                pend_blank <= bus.blank;
            end
            if (frame_end) begin
                pend_valid <= 1'b0;
                if (bus.load) begin
                    disp_val   <= nib_t'(bus.value);
                    disp_dp    <= bus.dp;
                    disp_blank <= bus.blank;
                end else if (pend_valid) begin
                    disp_val   <= pend_val;
                    disp_dp    <= pend_dp;
                    disp_blank <= pend_blank;
                end
            end else if (bus.load) begin
                pend_valid <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k>0 goes dark when it and every digit above it are zero.
    always_comb begin : lzb
        logic zero_above;
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above  = zero_above & (disp_val[k] == 4'h0);
            lz_blank[k] = zero_above;
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Next output values for the current (div_cnt, idx) position.
    always_comb begin
        in_guard = (int'(div_cnt) < GUARD);
        blanked  = disp_blank[idx] | lz_blank[idx];
        an_d     = in_guard ? '1 : ~(DIGITS'(1) << idx);
        seg_d    = (in_guard || blanked) ? 7'h7F : glyph(disp_val[idx]);
        dp_d     = in_guard || blanked || !disp_dp[idx];
    end

    // Registered pin drivers; frame_tick lines up with the last slot's outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an_n       <= '1;
            bus.seg_n      <= 7'h7F;
            bus.dp_n       <= 1'b1;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.an_n       <= an_d;
            bus.seg_n      <= seg_d;
            bus.dp_n       <= dp_d;
            bus.frame_tick <= frame_end;
        end
    end
endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display. It decodes one hex nibble per digit with the team's standard glyph set, including A-F. It scans the digits round-robin at a programmable slot rate and inserts an anti-ghosting guard interval. Input values are double-buffered so a frame never shows a mix of old and new digits. It sits between the datapath (counters, debug registers) and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned; legal range 1..8.
CLK_DIV, 50000, clk cycles per digit slot; must be >= 2.
GUARD, 2, cycles at the start of each slot with all anodes off; must be < CLK_DIV.

Ports:
clk  in  1  system clock; all state on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
value  in  4*DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k, digit 0 rightmost.
dp  in  DIGITS  decimal-point request per digit, active-high.
blank  in  DIGITS  per-digit blank request, active-high.
load  in  1  one-cycle strobe; captures value/dp/blank into the pending buffer.
seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
dp_n  out  1  decimal-point segment, active-low, registered.
an_n  out  DIGITS  digit anodes, active-low, one-hot-low or all-high, registered.
frame_tick  out  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset (async assert, sync release), all outputs and state: div_cnt=0, idx=0, an_n=all 1, seg_n=7'h7F, dp_n=1, frame_tick=0, display/pending buffers=0, pend_valid=0.
- div_cnt counts 0..CLK_DIV-1 and wraps. On wrap, idx advances 0..DIGITS-1 and wraps to 0.
- Outputs are registered, so they reflect the (div_cnt, idx) state of the previous cycle. First slot after reset is digit 0.
- Slot body: if div_cnt < GUARD, then an_n=all 1, seg_n=7'h7F, dp_n=1. Otherwise an_n[idx]=0 and all other an_n bits are 1.
- Blanked digit: if blank[idx] is set in the display buffer, seg_n=7'h7F and dp_n=1; the anode is still driven.
- Glyph table, seg_n hex: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- dp_n = ~dp[idx] from the display buffer, forced to 1 when blanked or in guard.
- Load path:
  - load=1 copies value/dp/blank into pending and sets pend_valid.
  - At frame end (idx=DIGITS-1 and div_cnt=CLK_DIV-1), if pend_valid, pending moves to display and pend_valid clears.
- Simultaneous load at frame end: the inputs in that cycle go straight into display and pend_valid ends 0. A value is never lost or shown one frame late.
- Multiple loads within one frame: the last one wins.
- frame_tick is asserted in the cycle after the frame-end state, aligned with the registered outputs.
- DIGITS=1: idx stays 0 and frame_tick pulses every CLK_DIV cycles.
- Reset mid-slot: outputs go to reset values immediately (async). Scanning restarts at digit 0, guard first.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: digit k>0 is blanked when nibbles k..DIGITS-1 of the display buffer are all zero. Digit 0 is never auto-blanked. An explicit blank bit still blanks, and an explicit dp on an auto-blanked digit is suppressed.
- Undefined: only the blank input blanks digits.

Test Plan:
1. DIGITS=4, CLK_DIV=4, GUARD=1; reset, then load value=16'h12AF, dp=0, blank=0 → after the next frame boundary, each 4-cycle slot shows 1 guard cycle (an_n=F, seg_n=7F), then 3 cycles with an_n=E/D/B/7 and seg_n=0E/08/24/79 respectively; frame_tick pulses every 16 cycles.
2. Load 16'h0000 in mid-frame, then 16'h5555 two cycles later → the current frame is unchanged; the next frame shows seg_n=12 on all digits (last load wins).
3. Load asserted exactly at frame end with value=16'h8888 → the very next frame shows seg_n=00 on all digits, and no stale frame appears.
4. dp=4'b0100, blank=4'b0001 → digit 2 shows dp_n=0 outside guard; digit 0 shows seg_n=7F and dp_n=1 while an_n[0]=0.
5. Assert rst_n=0 mid-slot of digit 2 → in the same cycle an_n=F, seg_n=7F, dp_n=1, frame_tick=0; after release the scan restarts at digit 0.
6. With LEADING_ZERO_BLANK_EN, value=16'h0030 → digits 3 and 2 show 7F, digit 1 shows 30, digit 0 shows 40. Without the macro, digits 3 and 2 show 40.
